instr_fetch_reg: RTL and testbench
==================================

// Module: instr_fetch_reg
// PURPOSE
//  Multicycle fetch stage and instruction register. On a control-unit fetch command it issues one
//  word read to instruction memory, waits for the ack and latches the word into IR. IR stays
//  stable for the rest of the instruction. Decoded fields (imm16 feeds the zero/sign extenders,
//  plus rs/rt/rd etc.) come straight from IR.
// PARAMETERS
//  TIMEOUT_CYCLES  255           max cycles mem_req stays high without ack (>=1)
//  RESET_IR        32'h0000_0000 IR value after reset (NOP)
//  PC_STEP         4             increment added to the fetch address for pc_next
// PORTS
//  clk          in   1   rising-edge clock
//  rst_n        in   1   asynchronous active-low reset
//  fetch_start  in   1   control unit requests fetch from pc_in (sampled in IDLE only)
//  abort        in   1   cancel an outstanding fetch (flush)
//  pc_in        in   32  fetch address
//  mem_req      out  1   read request to instruction memory
//  mem_addr     out  32  read address, stable while mem_req=1
//  mem_ack      in   1   memory has data on mem_rdata this cycle
//  mem_rdata    in   32  instruction word
//  ir           out  32  instruction register
//  opcode       out  6   ir[31:26]
//  rs           out  5   ir[25:21]
//  rt           out  5   ir[20:16]
//  rd           out  5   ir[15:11]
//  shamt        out  5   ir[10:6]
//  funct        out  6   ir[5:0]
//  imm16        out  16  ir[15:0]
//  jaddr        out  26  ir[25:0]
//  pc_next      out  32  fetch address + PC_STEP, registered with IR
//  ir_valid     out  1   one-cycle pulse: IR just loaded
//  busy         out  1   fetch in progress (equals mem_req)
//  timeout_err  out  1   sticky: last fetch timed out
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE, ir=RESET_IR, mem_req=0, mem_addr=0, pc_next=0,
//    ir_valid=0, busy=0, timeout_err=0, counter=0. Decoded fields follow ir.
//  - States: IDLE, WAIT.
//  - IDLE: at the edge with fetch_start=1, go to WAIT. Register mem_addr=pc_in, set mem_req=1,
//    clear the counter and clear timeout_err. mem_ack in IDLE is ignored.
//  - WAIT: mem_req=1, mem_addr held. fetch_start is ignored. Per edge, priority
//    abort > mem_ack > timeout:
//      abort=1   -> IDLE, mem_req=0, IR/pc_next unchanged, no ir_valid.
//      mem_ack=1 -> ir<=mem_rdata, pc_next<=mem_addr+PC_STEP (mod 2^32), ir_valid=1 for
//                   one cycle, mem_req=0, IDLE.
//      counter==TIMEOUT_CYCLES-1 and no ack -> timeout_err=1, mem_req=0, IDLE, IR unchanged.
//      otherwise counter+1.
//  - An ack in the last allowed cycle is accepted, not timed out.
//  - Latency: fetch_start at edge N -> mem_req high after N. Zero-wait ack at edge N+1 ->
//    ir/ir_valid after N+1. Each extra wait cycle adds 1.
//  - A new fetch can start the cycle after ir_valid (fetch_start sampled in IDLE).
//  - IR only changes on an accepted ack or on reset. Field outputs are purely combinational
//    from ir.
//  - pc_next wraps: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
//  - Reset mid-WAIT drops mem_req immediately (async) and restores every reset value.
// TESTING
//  1. Reset, then fetch_start with pc_in=0x40, zero-wait ack with rdata=0x2008_1234 ->
//     mem_addr=0x40, ir_valid 2 cycles after start, imm16=0x1234, rt=8, opcode=0x08, pc_next=0x44.
//  2. Ack after 3 wait cycles with rdata=0x0000_0020 -> mem_req high for 4 cycles,
//     funct=0x20, ir_valid single pulse.
//  3. TIMEOUT_CYCLES=4, no ack -> mem_req high exactly 4 cycles, timeout_err=1, IR unchanged.
//     Next fetch_start clears timeout_err.
//  4. abort and mem_ack in the same WAIT cycle -> no IR update, no ir_valid, IDLE, mem_req=0.
//  5. pc_in=0xFFFF_FFFC fetch -> pc_next=0x0000_0000. fetch_start pulsed during WAIT ->
//     ignored, mem_addr unchanged.
//  6. rst_n low mid-WAIT -> mem_req=0 with no clock edge, ir=RESET_IR, ir_valid=0.

Source files
------------

// File: rtl/instr_fetch_reg.sv
// Multicycle instruction fetch stage and instruction register.
// Issues one word read per fetch command, then latches the word and the next PC together.
module instr_fetch_reg #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] RESET_IR       = 32'h0000_0000,
    parameter int unsigned PC_STEP        = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_start,
    input  logic        abort,
    input  logic [31:0] pc_in,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] ir,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [15:0] imm16,
    output logic [25:0] jaddr,
    output logic [31:0] pc_next,
    output logic        ir_valid,
    output logic        busy,
    output logic        timeout_err
);

    // Counter only has to reach TIMEOUT_CYCLES-1.
    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CntLast = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e        state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   ir_q, ir_d;
    logic [31:0]   pcn_q, pcn_d;
    logic          valid_q, valid_d;
    logic          terr_q, terr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            addr_q  <= 32'h0;
            ir_q    <= RESET_IR;
            pcn_q   <= 32'h0;
            valid_q <= 1'b0;
            terr_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            ir_q    <= ir_d;
            pcn_q   <= pcn_d;
            valid_q <= valid_d;
            terr_q  <= terr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        ir_d    = ir_q;
        pcn_d   = pcn_q;
        valid_d = 1'b0;
        terr_d  = terr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (fetch_start) begin
                    state_d = StWait;
                    addr_d  = pc_in;
                    cnt_d   = '0;
                    terr_d  = 1'b0;
                end
            end
            StWait: begin
                // Priority: abort, then ack, then timeout; an ack on the last count wins.
                if (abort) begin
                    state_d = StIdle;
                end else if (mem_ack) begin
                    state_d = StIdle;
                    ir_d    = mem_rdata;
                    pcn_d   = addr_q + 32'(PC_STEP);
                    valid_d = 1'b1;
                end else if (cnt_q == CntLast) begin
                    state_d = StIdle;
                    terr_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign mem_req     = (state_q == StWait);
    assign busy        = mem_req;
    assign mem_addr    = addr_q;
    assign ir          = ir_q;
    assign pc_next     = pcn_q;
    assign ir_valid    = valid_q;
    assign timeout_err = terr_q;

    assign opcode = ir_q[31:26];
    assign rs     = ir_q[25:21];
    assign rt     = ir_q[20:16];
    assign rd     = ir_q[15:11];
    assign shamt  = ir_q[10:6];
    assign funct  = ir_q[5:0];
    assign imm16  = ir_q[15:0];
    assign jaddr  = ir_q[25:0];

endmodule

// File: tb/tb_instr_fetch_reg.sv
// Directed self-checking bench for instr_fetch_reg with a short timeout of 4 cycles.
module tb_instr_fetch_reg;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] pc_in = 32'h0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic [31:0] ir;
    logic [5:0]  opcode;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [15:0] imm16;
    logic [25:0] jaddr;
    logic [31:0] pc_next;
    logic        ir_valid, busy, timeout_err;

    int n_cmp = 0;
    int n_mis = 0;

    instr_fetch_reg #(
        .TIMEOUT_CYCLES(4),
        .RESET_IR      (32'h0000_0000),
        .PC_STEP       (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fetch_start(fetch_start),
        .abort      (abort),
        .pc_in      (pc_in),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .ir         (ir),
        .opcode     (opcode),
        .rs         (rs),
        .rt         (rt),
        .rd         (rd),
        .shamt      (shamt),
        .funct      (funct),
        .imm16      (imm16),
        .jaddr      (jaddr),
        .pc_next    (pc_next),
        .ir_valid   (ir_valid),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_cmp++; if (mem_req !== 1'b0) begin n_mis++; $display("FAIL rst_mem_req got %b want 0", mem_req); end
        n_cmp++; if (ir !== 32'h0) begin n_mis++; $display("FAIL rst_ir got %h want 0", ir); end
        rst_n = 1'b1;
        step();
        n_cmp++; if (pc_next !== 32'h0) begin n_mis++; $display("FAIL rst_pc_next got %h want 0", pc_next); end
        n_cmp++; if ({ir_valid, busy, timeout_err} !== 3'b000) begin n_mis++; $display("FAIL rst_flags got %b want 000", {ir_valid, busy, timeout_err}); end
        n_cmp++; if (mem_addr !== 32'h0) begin n_mis++; $display("FAIL rst_mem_addr got %h want 0", mem_addr); end
    endtask

    task automatic test_zero_wait();
        pc_in = 32'h40; fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        n_cmp++; if (mem_req !== 1'b1 || busy !== 1'b1) begin n_mis++; $display("FAIL zw_req got %b/%b want 1/1", mem_req, busy); end
        n_cmp++; if (mem_addr !== 32'h40) begin n_mis++; $display("FAIL zw_addr got %h want 00000040", mem_addr); end
        n_cmp++; if (ir_valid !== 1'b0) begin n_mis++; $display("FAIL zw_early_valid got %b want 0", ir_valid); end
        mem_ack = 1'b1; mem_rdata = 32'h2008_1234;
        step();
        mem_ack = 1'b0;
        n_cmp++; if (ir_valid !== 1'b1) begin n_mis++; $display("FAIL zw_valid got %b want 1", ir_valid); end
        n_cmp++; if (ir !== 32'h2008_1234) begin n_mis++; $display("FAIL zw_ir got %h want 20081234", ir); end
        n_cmp++; if (imm16 !== 16'h1234 || rt !== 5'd8 || opcode !== 6'h08 || rs !== 5'd0) begin
            n_mis++; $display("FAIL zw_fields got imm=%h rt=%0d op=%h rs=%0d want 1234/8/08/0", imm16, rt, opcode, rs);
        end
        n_cmp++; if (pc_next !== 32'h44) begin n_mis++; $display("FAIL zw_pc_next got %h want 00000044", pc_next); end
        n_cmp++; if (mem_req !== 1'b0) begin n_mis++; $display("FAIL zw_req_drop got %b want 0", mem_req); end
        step();
        n_cmp++; if (ir_valid !== 1'b0) begin n_mis++; $display("FAIL zw_pulse got %b want 0", ir_valid); end
    endtask

    task automatic test_wait_states();
        pc_in = 32'h100; fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (mem_req !== 1'b1 || ir_valid !== 1'b0) begin
                n_mis++; $display("FAIL ws_hold%0d got req=%b valid=%b want 1/0", k, mem_req, ir_valid);
            end
            step();
        end
        // Fourth cycle is the last allowed one: the ack must still be accepted.
        n_cmp++; if (mem_req !== 1'b1) begin n_mis++; $display("FAIL ws_req4 got %b want 1", mem_req); end
        mem_ack = 1'b1; mem_rdata = 32'h0000_0020;
        step();
        mem_ack = 1'b0;
        n_cmp++; if (ir_valid !== 1'b1 || funct !== 6'h20 || ir !== 32'h20) begin
            n_mis++; $display("FAIL ws_load got valid=%b funct=%h ir=%h want 1/20/00000020", ir_valid, funct, ir);
        end
        n_cmp++; if (timeout_err !== 1'b0 || mem_req !== 1'b0) begin
            n_mis++; $display("FAIL ws_status got terr=%b req=%b want 0/0", timeout_err, mem_req);
        end
        n_cmp++; if (pc_next !== 32'h104) begin n_mis++; $display("FAIL ws_pc_next got %h want 00000104", pc_next); end
        step();
        n_cmp++; if (ir_valid !== 1'b0) begin n_mis++; $display("FAIL ws_pulse got %b want 0", ir_valid); end
    endtask

    task automatic test_timeout();
        pc_in = 32'h200; fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (mem_req !== 1'b1 || timeout_err !== 1'b0) begin
                n_mis++; $display("FAIL to_hold%0d got req=%b terr=%b want 1/0", k, mem_req, timeout_err);
            end
            step();
        end
        n_cmp++; if (mem_req !== 1'b0 || timeout_err !== 1'b1) begin
            n_mis++; $display("FAIL to_expire got req=%b terr=%b want 0/1", mem_req, timeout_err);
        end
        n_cmp++; if (ir !== 32'h20 || ir_valid !== 1'b0 || pc_next !== 32'h104) begin
            n_mis++; $display("FAIL to_ir_kept got ir=%h valid=%b pcn=%h want 00000020/0/00000104", ir, ir_valid, pc_next);
        end
        step();
        n_cmp++; if (timeout_err !== 1'b1) begin n_mis++; $display("FAIL to_sticky got %b want 1", timeout_err); end
        pc_in = 32'h300; fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        n_cmp++; if (timeout_err !== 1'b0 || mem_req !== 1'b1) begin
            n_mis++; $display("FAIL to_clear got terr=%b req=%b want 0/1", timeout_err, mem_req);
        end
    endtask

    task automatic test_abort();
        // Still waiting on the 0x300 fetch from the previous task.
        abort = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        step();
        abort = 1'b0;
        n_cmp++; if (mem_req !== 1'b0 || busy !== 1'b0 || ir_valid !== 1'b0) begin
            n_mis++; $display("FAIL ab_idle got req=%b busy=%b valid=%b want 0/0/0", mem_req, busy, ir_valid);
        end
        n_cmp++; if (ir !== 32'h20 || pc_next !== 32'h104) begin
            n_mis++; $display("FAIL ab_ir got ir=%h pcn=%h want 00000020/00000104", ir, pc_next);
        end
        step();
        mem_ack = 1'b0;
        n_cmp++; if (ir !== 32'h20 || ir_valid !== 1'b0) begin
            n_mis++; $display("FAIL idle_ack got ir=%h valid=%b want 00000020/0", ir, ir_valid);
        end
    endtask

    task automatic test_wrap_ignore();
        pc_in = 32'hFFFF_FFFC; fetch_start = 1'b1;
        step();
        pc_in = 32'h500;
        step();
        fetch_start = 1'b0;
        n_cmp++; if (mem_addr !== 32'hFFFF_FFFC || mem_req !== 1'b1) begin
            n_mis++; $display("FAIL wr_ignore got addr=%h req=%b want fffffffc/1", mem_addr, mem_req);
        end
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        step();
        mem_ack = 1'b0;
        n_cmp++; if (pc_next !== 32'h0) begin n_mis++; $display("FAIL wr_pc_next got %h want 00000000", pc_next); end
        n_cmp++; if (ir !== 32'h1234_5678 || rd !== 5'h0A || shamt !== 5'h19 || jaddr !== 26'h234_5678) begin
            n_mis++; $display("FAIL wr_fields got ir=%h rd=%h sh=%h j=%h want 12345678/0a/19/2345678", ir, rd, shamt, jaddr);
        end
        step();
        n_cmp++; if (mem_req !== 1'b0 || ir_valid !== 1'b0) begin
            n_mis++; $display("FAIL wr_after got req=%b valid=%b want 0/0", mem_req, ir_valid);
        end
    endtask

    task automatic test_async_reset();
        pc_in = 32'h600; fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        n_cmp++; if (mem_req !== 1'b1) begin n_mis++; $display("FAIL ar_pre got %b want 1", mem_req); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (mem_req !== 1'b0 || busy !== 1'b0) begin
            n_mis++; $display("FAIL ar_req got req=%b busy=%b want 0/0", mem_req, busy);
        end
        n_cmp++; if (ir !== 32'h0 || ir_valid !== 1'b0 || pc_next !== 32'h0 || mem_addr !== 32'h0) begin
            n_mis++; $display("FAIL ar_state got ir=%h valid=%b pcn=%h addr=%h want all 0", ir, ir_valid, pc_next, mem_addr);
        end
        #3 rst_n = 1'b1;
        step();
        n_cmp++; if (mem_req !== 1'b0 || timeout_err !== 1'b0) begin
            n_mis++; $display("FAIL ar_after got req=%b terr=%b want 0/0", mem_req, timeout_err);
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_timeout();
        test_abort();
        test_wrap_ignore();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
